picorv32_mem_arbiter: RTL and testbench

PICORV32_MEM_ARBITER -- requirements
Module: picorv32_mem_arbiter

---
 rtl/picorv32_mem_arbiter_pkg.sv | 13 +
 rtl/picorv32_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared definitions for the two-master PicoRV32 memory arbiter.
//   arb_state_e    : arbiter FSM state encoding (idle / transaction in flight)
//   DefaultTimeout : default slave wait budget before a transaction is forced to complete
package picorv32_mem_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultTimeout = 16;

endpackage

// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter in front of a single PicoRV32-style native memory port.
// One transaction is in flight at a time. A slave that stalls too long is cut off
// by a forced completion (rdata = 0), which sets a sticky error flag.
//
// Parameters
//   TIMEOUT     : slave wait cycles tolerated before forced completion, 0 disables
//   ROUND_ROBIN : 1 = alternate priority between masters, 0 = m0 always wins
// Ports
//   clk, resetn                       : clock (rising edge), async active-low reset
//   mN_valid/instr/addr/wdata/wstrb   : master N request, held until mN_ready
//   mN_ready, mN_rdata                : master N completion pulse and read data
//   mem_valid/instr/addr/wdata/wstrb  : slave request carrying the granted master's fields
//   mem_ready, mem_rdata              : slave completion and read data
//   grant                             : granted master index (meaningful while busy)
//   timeout_err                       : sticky, set on any forced completion
module picorv32_mem_arbiter
    import picorv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT     = DefaultTimeout,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        grant,
    output logic        timeout_err
);

    // A zero-width counter is illegal, so keep one bit even when the timeout is disabled.
    localparam int unsigned   CntW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TimeoutEn  = (TIMEOUT > 0);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntMax     = '1;

    arb_state_e      state_q;
    logic            grant_q;
    logic            prio_q;        // master preferred when both request
    logic            timeout_err_q;
    logic [CntW-1:0] wait_cnt_q;

    logic        busy;
    logic        timeout_hit;
    logic        done;
    logic        any_req;
    logic        winner;
    logic [31:0] resp_data;

    assign busy        = (state_q == StBusy);
    // A real mem_ready takes precedence over the timeout in the same cycle.
    assign timeout_hit = TimeoutEn && busy && !mem_ready && (wait_cnt_q == TimeoutVal);
    assign done        = busy && (mem_ready || timeout_hit);
    assign any_req     = m0_valid || m1_valid;

    always_comb begin
        winner = m0_valid ? 1'b0 : 1'b1;
        if (m0_valid && m1_valid) begin
            winner = ROUND_ROBIN ? prio_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            prio_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q    <= StBusy;
                        grant_q    <= winner;
                        prio_q     <= ~winner;
                        wait_cnt_q <= '0;
                    end
                end
                StBusy: begin
                    if (done) begin
                        state_q <= StIdle;
                        if (timeout_hit) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else if (wait_cnt_q != CntMax) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_valid   = busy;
    assign mem_instr   = grant_q ? m1_instr : m0_instr;
    assign mem_addr    = grant_q ? m1_addr  : m0_addr;
    assign mem_wdata   = grant_q ? m1_wdata : m0_wdata;
    assign mem_wstrb   = grant_q ? m1_wstrb : m0_wstrb;

    // Forced completions return zero data.
    assign resp_data   = mem_ready ? mem_rdata : 32'h0;

    assign m0_ready    = done && !grant_q;
    assign m1_ready    = done && grant_q;
    assign m0_rdata    = m0_ready ? resp_data : 32'h0;
    assign m1_rdata    = m1_ready ? resp_data : 32'h0;

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter. Two instances share all inputs:
// dut_a (round-robin) and dut_b (fixed m0 priority), both with TIMEOUT = 4.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_picorv32_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        a_m0_ready, a_m1_ready, a_mem_valid, a_mem_instr, a_grant, a_timeout_err;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic        b_m0_ready, b_m1_ready, b_mem_valid, b_mem_instr, b_grant, b_timeout_err;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    picorv32_mem_arbiter #(.TIMEOUT(4), .ROUND_ROBIN(1'b1)) dut_a (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
        .mem_valid(a_mem_valid), .mem_instr(a_mem_instr), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .grant(a_grant), .timeout_err(a_timeout_err)
    );

    picorv32_mem_arbiter #(.TIMEOUT(4), .ROUND_ROBIN(1'b0)) dut_b (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
        .mem_valid(b_mem_valid), .mem_instr(b_mem_instr), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .grant(b_grant), .timeout_err(b_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    // Returns on a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_valid", a_mem_valid, 0);
        check("rst_grant", a_grant, 0);
        check("rst_timeout_err", a_timeout_err, 0);
        check("rst_m0_ready", a_m0_ready, 0);
        resetn = 1'b1;

        // Single read from m0, slave answers on the third busy cycle.
        @(negedge clk);
        m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0; m0_instr = 1;
        #1 check("rd_idle_valid", a_mem_valid, 0);
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                mem_ready = 1; mem_rdata = 32'hDEADBEEF;
            end
            #1;
            check("rd_mem_valid", a_mem_valid, 1);
            check("rd_mem_addr", a_mem_addr, 32'h100);
            check("rd_m0_ready", a_m0_ready, (c == 3) ? 1 : 0);
            if (a_m0_ready) pulses++;
            if (c == 3) begin
                check("rd_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
                check("rd_m1_rdata", a_m1_rdata, 0);
            end
        end
        @(negedge clk);
        m0_valid = 0; mem_ready = 0; mem_rdata = 0;
        #1;
        if (a_m0_ready) pulses++;
        check("rd_done_valid", a_mem_valid, 0);
        check("rd_pulses", pulses, 1);

        // Both masters request continuously; slave answers on the first busy cycle.
        do_reset();
        m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_valid = 1; m1_valid = 1; mem_ready = 0;
            #1 check("rr_idle_gap", a_mem_valid, 0);
            @(negedge clk);
            mem_ready = 1; mem_rdata = 32'hA000_0000 + i;
            #1;
            check("rr_grant", a_grant, i % 2);
            check("rr_addr", a_mem_addr, (i % 2) ? 32'h200 : 32'h100);
            check("rr_ready", (i % 2) ? a_m1_ready : a_m0_ready, 1);
            check("rr_rdata", (i % 2) ? a_m1_rdata : a_m0_rdata, 32'hA000_0000 + i);
            check("rr_other_rdata", (i % 2) ? a_m0_rdata : a_m1_rdata, 0);
            check("fp_grant", b_grant, 0);
            check("fp_m1_starve", b_m1_ready, 0);
        end
        @(negedge clk);
        m0_valid = 0; m1_valid = 0; mem_ready = 0;
        #1 check("rr_end_idle", a_mem_valid, 0);

        // mem_ready while idle is ignored.
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h99;
        #1;
        check("idle_m0_ready", a_m0_ready, 0);
        check("idle_m1_ready", a_m1_ready, 0);
        @(negedge clk);
        #1 check("idle_stays_idle", a_mem_valid, 0);

        // Timeout on an m1 write; m1 drops valid mid-transaction.
        @(negedge clk);
        mem_ready = 0; mem_rdata = 32'h5555AAAA;
        m1_valid = 1; m1_wstrb = 4'hF; m1_wdata = 32'hCAFEF00D; m1_addr = 32'h300;
        #1 check("to_err_before", a_timeout_err, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) m1_valid = 0;
            #1;
            check("to_mem_valid", a_mem_valid, 1);
            check("to_m1_ready", a_m1_ready, (c == 5) ? 1 : 0);
            if (c == 1) begin
                check("to_wstrb", a_mem_wstrb, 4'hF);
                check("to_wdata", a_mem_wdata, 32'hCAFEF00D);
            end
            if (c == 5) begin
                check("to_rdata_zero", a_m1_rdata, 0);
                check("to_err_not_yet", a_timeout_err, 0);
            end
        end
        @(negedge clk);
        #1;
        check("to_err_set", a_timeout_err, 1);
        check("to_err_set_b", b_timeout_err, 1);
        check("to_idle", a_mem_valid, 0);

        // A normal transaction afterwards leaves the sticky flag set.
        @(negedge clk);
        m0_valid = 1; m0_wstrb = 4'h0; m0_addr = 32'h104;
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h11;
        #1 check("post_to_ready", a_m0_ready, 1);
        @(negedge clk);
        m0_valid = 0; mem_ready = 0;
        #1 check("to_err_held", a_timeout_err, 1);

        // mem_ready coincides with the timeout: normal completion wins.
        do_reset();
        #1 check("co_err_cleared", a_timeout_err, 0);
        @(negedge clk);
        m0_valid = 1; m0_addr = 32'h400;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 5) begin
                mem_ready = 1; mem_rdata = 32'h12345678;
            end
            #1;
            check("co_m0_ready", a_m0_ready, (c == 5) ? 1 : 0);
            if (c == 5) check("co_rdata", a_m0_rdata, 32'h12345678);
        end
        @(negedge clk);
        m0_valid = 0; mem_ready = 0;
        #1;
        check("co_err_zero", a_timeout_err, 0);
        check("co_idle", a_mem_valid, 0);

        // Reset mid-busy: immediate drop, no late ready, pointer back to m0.
        @(negedge clk);
        m0_valid = 1; m0_addr = 32'h500;
        @(negedge clk);
        #1 check("mr_busy", a_mem_valid, 1);
        #1 resetn = 1'b0;
        #1;
        check("mr_async_valid", a_mem_valid, 0);
        check("mr_async_grant", a_grant, 0);
        m0_valid = 0; mem_ready = 1; mem_rdata = 32'h77;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("mr_no_m0_ready", a_m0_ready, 0);
            check("mr_no_m1_ready", a_m1_ready, 0);
            check("mr_idle", a_mem_valid, 0);
        end
        @(negedge clk);
        m0_valid = 1; m1_valid = 1; mem_ready = 0;
        #1 check("mr_req_idle", a_mem_valid, 0);
        @(negedge clk);
        #1;
        check("mr_busy_again", a_mem_valid, 1);
        check("mr_grant_m0", a_grant, 0);

        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
